// File: rtl/sub_ctrl_pkg.sv
// rtl/sub_ctrl_pkg.sv - shared types and defaults for the bit-serial subtractor controller
package sub_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell: in1 - in2 - in3
module full_subtractor (
   input  logic in1,
   input  logic in2,
   input  logic in3,
   output logic Diff,
   output logic Borrow
);

   assign Diff   = in1 ^ in2 ^ in3;
   assign Borrow = (~in1 & in2) | (~(in1 ^ in2) & in3);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - LSB-first serial A - B - bin over WIDTH cycles using one cell
module serial_subtractor_ctrl
   import sub_ctrl_pkg::*;
#(
   parameter  int WIDTH = SUB_WIDTH_DEF,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic             r_brw;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   logic             w_diff;
   logic             w_borrow;

   full_subtractor u_cell (
      .in1    (r_a_sh[0]),
      .in2    (r_b_sh[0]),
      .in3    (r_brw),
      .Diff   (w_diff),
      .Borrow (w_borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_brw    <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_brw   <= bin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_brw    <= w_borrow;
               r_res_sh <= {w_diff, r_res_sh[WIDTH-1:1]};
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_cnt    <= r_cnt + CNT_W'(1);
               // Capture the final bit directly so the result is visible during DONE itself.
               if (r_cnt == LAST_BIT) begin
                  r_diff  <= {w_diff, r_res_sh[WIDTH-1:1]};
                  r_bout  <= w_borrow;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - directed self-checking bench for serial_subtractor_ctrl
module tb_serial_subtractor_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;

   int checks   = 0;
   int failures = 0;
   int cycle_no = 0;

   serial_subtractor_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_no <= cycle_no + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Samples at negedges; cycle 1 is the one right after the accepting edge.
   task automatic wait_done(output int cyc, output int busy_cnt, output bit ok);
      cyc = 0;
      busy_cnt = 0;
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
         if (done) ok = 1'b1;
      end
   endtask

   task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, input logic [7:0] ed, input logic eb,
                        output int lat, output int bcnt);
      bit ok;
      @(negedge clk);
      a = ta; b = tb_v; bin = tbin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, bcnt, ok);
      check_eq({tag, "_done_seen"}, 32'(ok), 32'd1);
      check_eq({tag, "_diff"}, 32'(diff), 32'(ed));
      check_eq({tag, "_bout"}, 32'(bout), 32'(eb));
      @(negedge clk);
      check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   logic [7:0] ra   [3];
   logic [7:0] rb   [3];
   logic       rbin [3];
   int         t_done [3];

   initial begin
      int lat, bcnt, ndone;
      logic [7:0] cap_diff;
      logic       cap_bout;
      logic [8:0] ref_v;
      bit ok;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #12;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_diff", 32'(diff), 32'd0);
      check_eq("rst_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle_no_start_busy", 32'(busy), 32'd0);

      do_op("op5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, lat, bcnt);
      check_eq("latency_cycles", 32'(lat), 32'd9);
      check_eq("busy_cycles", 32'(bcnt), 32'd9);

      do_op("op00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, lat, bcnt);
      do_op("opff_ff_b1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, lat, bcnt);
      do_op("op80_00_b1", 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, lat, bcnt);

      // start pulsed in RUN cycle 3 with a different minuend
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; a = 8'h11;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; cap_diff = '0; cap_bout = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            cap_diff = diff;
            cap_bout = bout;
         end
      end
      check_eq("ignore_done_count", 32'(ndone), 32'd1);
      check_eq("ignore_diff", 32'(cap_diff), 32'h1E);
      check_eq("ignore_bout", 32'(cap_bout), 32'd0);

      // asynchronous reset in RUN cycle 4
      @(negedge clk);
      a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_done", 32'(done), 32'd0);
      check_eq("arst_diff", 32'(diff), 32'd0);
      check_eq("arst_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check_eq("arst_no_done", 32'(ndone), 32'd0);
      check_eq("arst_idle_busy", 32'(busy), 32'd0);
      do_op("op10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, lat, bcnt);

      // start held high across three operations
      for (int i = 0; i < 3; i++) begin
         ra[i]   = 8'($urandom);
         rb[i]   = 8'($urandom);
         rbin[i] = 1'($urandom);
      end
      @(negedge clk);
      a = ra[0]; b = rb[0]; bin = rbin[0]; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ok = 1'b0;
         for (int k = 0; k < 20 && !ok; k++) begin
            if (busy) ok = 1'b1;
            else @(negedge clk);
         end
         check_eq("b2b_accept", 32'(ok), 32'd1);
         if (i < 2) begin
            a = ra[i+1]; b = rb[i+1]; bin = rbin[i+1];
         end
         wait_done(lat, bcnt, ok);
         check_eq("b2b_done_seen", 32'(ok), 32'd1);
         t_done[i] = cycle_no;
         ref_v = {1'b0, ra[i]} - {1'b0, rb[i]} - {8'd0, rbin[i]};
         check_eq("b2b_diff", 32'(diff), 32'(ref_v[7:0]));
         check_eq("b2b_bout", 32'(bout), 32'(ref_v[8]));
         if (i > 0) check_eq("b2b_period", 32'(t_done[i] - t_done[i-1]), 32'd10);
         if (i < 2) begin
            ok = 1'b0;
            for (int k = 0; k < 5 && !ok; k++) begin
               @(negedge clk);
               if (!busy) ok = 1'b1;
            end
            check_eq("b2b_idle_gap", 32'(ok), 32'd1);
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("final_idle_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
